issue_unit: RTL
===============

// Module: issue_unit
// PURPOSE
//  Per-SM issue arbiter at the consumer end of the IBuffer issue handshake. Each cycle it picks at
//  most one requesting warp (req_IB_IU) for issue to the Operand Collector, and at most one warp
//  (exit_req_IB_IU) for release to the RAU. Both picks are round-robin.
//  It also holds branch-pending and exited state per warp, so a warp cannot issue past an
//  unresolved BEQ/BLT, and cannot issue again after EXIT until the RAU restarts it.
// PARAMETERS
//  NUM_WARPS     8                    warps per SM; must be a power of 2, >= 2
//  LOGNUM_WARPS  $clog2(NUM_WARPS)    warp ID width
// PORTS
//  clk                  in   1             clock
//  rst                  in   1             synchronous, active-high reset
//  req_IB_IU            in   NUM_WARPS     per-warp issue request from IBuffer
//  grt_IU_IB            out  NUM_WARPS     one-hot (or zero) issue grant, combinational
//  exit_req_IB_IU       in   NUM_WARPS     per-warp exit request from IBuffer
//  exit_grt_IU_IB       out  NUM_WARPS     one-hot (or zero) exit grant, combinational
//  BEQ_IB_OC            in   1             granted instruction is a BEQ (IBuffer output mux, same cycle)
//  BLT_IB_OC            in   1             granted instruction is a BLT (same cycle)
//  OC_full_OC_IU        in   1             Operand Collector cannot accept; blocks all issue grants
//  br_resolve_valid_SIMT_IU  in 1          SIMT has resolved a branch this cycle
//  br_resolve_warpID_SIMT_IU in LOGNUM_WARPS  warp whose branch is resolved
//  warp_start_RAU_IU    in   NUM_WARPS     RAU (re)allocates warp; clears its exited bit
//  issue_count_IU       out  32            issued-instruction counter, saturating
// BEHAVIOUR
//  State: rr_ptr, exit_ptr [LOGNUM_WARPS-1:0]; br_pend[NUM_WARPS], exited[NUM_WARPS];
//  issue_count[31:0].
//  - Reset: all state is 0. While rst=1, grt_IU_IB=0 and exit_grt_IU_IB=0. issue_count_IU reads 0.
//  - Issue eligibility: elig = req & ~br_pend & ~exited, with all bits forced to 0 if OC_full_OC_IU=1.
//  - Issue grant: the first set bit of elig, scanning rr_ptr, rr_ptr+1, ... with wrap modulo
//    NUM_WARPS. grt is 0 if elig=0. Zero latency, purely combinational from inputs and state.
//  - On an issue grant to warp w: rr_ptr <= (w+1) mod NUM_WARPS at the next edge. With no grant,
//    rr_ptr holds.
//  - Branch lock: if warp w is granted and (BEQ_IB_OC | BLT_IB_OC), then br_pend[w] <= 1. Warp w is
//    not eligible from the next cycle until a resolve arrives.
//  - Resolve: br_resolve_valid=1 clears br_pend[br_resolve_warpID]. A resolve for a warp with no
//    pending branch is ignored.
//  - Set and clear of the same bit in one cycle cannot occur, because a pending warp is masked. If
//    it does occur, set wins.
//  - Exit eligibility: exit_elig = exit_req & ~exited & ~br_pend & ~grt_IU_IB. A warp is never
//    issue- and exit-granted in the same cycle. OC_full does not block exit.
//  - Exit grant: round-robin from exit_ptr, same scan rule as issue. On an exit grant to w:
//    exit_ptr <= (w+1) mod NUM_WARPS and exited[w] <= 1.
//  - Issue grant and exit grant to different warps may happen in the same cycle.
//  - warp_start_RAU_IU[w]=1 clears exited[w] and br_pend[w] at the next edge. It takes priority over
//    a same-cycle exit grant to w.
//  - issue_count increments by 1 per cycle with grt != 0 and saturates at 32'hFFFF_FFFF.
//  - Invariants, checked by assertion: $onehot0(grt_IU_IB); $onehot0(exit_grt_IU_IB);
//    (grt_IU_IB & exit_grt_IU_IB) == 0; grt_IU_IB is a subset of req_IB_IU.
//  - Reset mid-operation: all pending and exited state is lost. Grants resume from warp 0 on the
//    cycle after rst falls.
// TESTING
//  1. Reset, then req=8'hFF held for 8 cycles -> grt = 01,02,04,...,80, then 01 again;
//     issue_count=8 after 8 cycles.
//  2. req=8'h81 with rr_ptr=7 -> grt=8'h80, then 8'h01, then 8'h80 (wrap-around fairness).
//  3. Warp 3 granted with BEQ_IB_OC=1 -> grt[3]=0 while req[3]=1 for 5 cycles. Resolve
//     valid=1, warpID=3 -> grt[3]=1 on the next cycle.
//  4. OC_full=1 with req=8'hFF and exit_req=8'h04 -> grt=0 and exit_grt=8'h04. Next cycle:
//     exited[2]=1 and req[2] is never granted until warp_start[2]=1.
//  5. req=8'h02 and exit_req=8'h02 in the same cycle -> grt=8'h02, exit_grt=0. When req drops,
//     exit_grt=8'h02.
//  6. issue_count preloaded by force to 32'hFFFF_FFFE, two grants -> 32'hFFFF_FFFF, and it holds.
//     Assert rst mid-stream -> all outputs 0 and the counter is 0.

Source files
------------

// File: rtl/issue_unit.sv
// ---------------------------------------------------------------------------
// issue_unit
//   Per-SM issue arbiter sitting at the consumer end of the IBuffer issue
//   handshake. Each cycle it picks at most one requesting warp for issue to
//   the Operand Collector and, independently, at most one warp for release to
//   the RAU. Both picks are round-robin. It also tracks per-warp
//   branch-pending and exited state, so a warp cannot issue past an
//   unresolved BEQ/BLT and cannot issue again after EXIT until the RAU
//   restarts it.
//
// Handshake: req_IB_IU[w] / exit_req_IB_IU[w] are the per-warp valids and
//   grt_IU_IB[w] / exit_grt_IU_IB[w] are the matching readies. A transfer
//   happens in the cycle where both are high. Grants are combinational from
//   the requests and the current state, and a valid may drop at any time.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_IB_IU      [N]         per-warp issue request
//   grt_IU_IB      [N]         one-hot/zero issue grant
//   exit_req_IB_IU [N]         per-warp exit request
//   exit_grt_IU_IB [N]         one-hot/zero exit grant
//   BEQ_IB_OC, BLT_IB_OC       granted instruction is a conditional branch
//   OC_full_OC_IU              Operand Collector full, blocks issue grants
//   br_resolve_valid_SIMT_IU   a branch has been resolved this cycle
//   br_resolve_warpID_SIMT_IU  warp whose branch is resolved
//   warp_start_RAU_IU [N]      RAU (re)starts a warp, clears exited/br_pend
//   issue_count_IU [32]        saturating issued-instruction counter
// ---------------------------------------------------------------------------
module issue_unit #(
  parameter int NUM_WARPS    = 8,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    req_IB_IU,
  output logic [NUM_WARPS-1:0]    grt_IU_IB,
  input  logic [NUM_WARPS-1:0]    exit_req_IB_IU,
  output logic [NUM_WARPS-1:0]    exit_grt_IU_IB,
  input  logic                    BEQ_IB_OC,
  input  logic                    BLT_IB_OC,
  input  logic                    OC_full_OC_IU,
  input  logic                    br_resolve_valid_SIMT_IU,
  input  logic [LOGNUM_WARPS-1:0] br_resolve_warpID_SIMT_IU,
  input  logic [NUM_WARPS-1:0]    warp_start_RAU_IU,
  output logic [31:0]             issue_count_IU
);

  // State
  logic [LOGNUM_WARPS-1:0] rr_ptr;
  logic [LOGNUM_WARPS-1:0] exit_ptr;
  logic [NUM_WARPS-1:0]    br_pend;
  logic [NUM_WARPS-1:0]    exited;
  logic [31:0]             issue_count;

  // Next state
  logic [LOGNUM_WARPS-1:0] rr_ptr_nxt;
  logic [LOGNUM_WARPS-1:0] exit_ptr_nxt;
  logic [NUM_WARPS-1:0]    br_pend_nxt;
  logic [NUM_WARPS-1:0]    exited_nxt;
  logic [31:0]             issue_count_nxt;

  // Arbitration
  logic [NUM_WARPS-1:0]    elig;
  logic [NUM_WARPS-1:0]    exit_elig;
  logic [NUM_WARPS-1:0]    grt;
  logic [NUM_WARPS-1:0]    exit_grt;
  logic                    grt_any;
  logic                    exit_any;
  logic [LOGNUM_WARPS-1:0] grt_id;
  logic [LOGNUM_WARPS-1:0] exit_id;

  // -------------------------------------------------------------------------
  // Issue pick: scan rr_ptr, rr_ptr+1, ... The index sum is LOGNUM_WARPS bits
  // wide, so the wrap modulo NUM_WARPS comes for free (NUM_WARPS is 2^k).
  // Grants are suppressed during reset.
  // -------------------------------------------------------------------------
  always_comb begin : issue_pick
    grt     = '0;
    grt_any = 1'b0;
    grt_id  = '0;
    if (rst || OC_full_OC_IU) elig = '0;
    else                      elig = req_IB_IU & ~br_pend & ~exited;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!grt_any && elig[rr_ptr + LOGNUM_WARPS'(i)]) begin
        grt_any = 1'b1;
        grt_id  = rr_ptr + LOGNUM_WARPS'(i);
      end
    end
    if (grt_any) grt[grt_id] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Exit pick: same scan from exit_ptr. Masking with the issue grant keeps a
  // warp from being issue- and exit-granted in the same cycle. OC_full does
  // not apply here.
  // -------------------------------------------------------------------------
  always_comb begin : exit_pick
    exit_grt = '0;
    exit_any = 1'b0;
    exit_id  = '0;
    if (rst) exit_elig = '0;
    else     exit_elig = exit_req_IB_IU & ~exited & ~br_pend & ~grt;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!exit_any && exit_elig[exit_ptr + LOGNUM_WARPS'(i)]) begin
        exit_any = 1'b1;
        exit_id  = exit_ptr + LOGNUM_WARPS'(i);
      end
    end
    if (exit_any) exit_grt[exit_id] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // br_pend priority (lowest to highest): resolve clear, branch set, restart
  // clear. A resolve for a non-pending warp is a harmless no-op.
  // exited: restart clear beats a same-cycle exit grant.
  // -------------------------------------------------------------------------
  always_comb begin : next_state
    br_pend_nxt = br_pend;
    if (br_resolve_valid_SIMT_IU)
      br_pend_nxt[br_resolve_warpID_SIMT_IU] = 1'b0;
    if (grt_any && (BEQ_IB_OC || BLT_IB_OC))
      br_pend_nxt[grt_id] = 1'b1;
    br_pend_nxt = br_pend_nxt & ~warp_start_RAU_IU;

    exited_nxt = (exited | exit_grt) & ~warp_start_RAU_IU;

    rr_ptr_nxt   = grt_any  ? grt_id  + LOGNUM_WARPS'(1) : rr_ptr;
    exit_ptr_nxt = exit_any ? exit_id + LOGNUM_WARPS'(1) : exit_ptr;

    if (grt_any && (issue_count != 32'hFFFF_FFFF))
      issue_count_nxt = issue_count + 32'd1;
    else
      issue_count_nxt = issue_count;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      rr_ptr      <= '0;
      exit_ptr    <= '0;
      br_pend     <= '0;
      exited      <= '0;
      issue_count <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      exit_ptr    <= exit_ptr_nxt;
      br_pend     <= br_pend_nxt;
      exited      <= exited_nxt;
      issue_count <= issue_count_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The counter reads zero for the whole reset window, including the
  // first cycle before the synchronous clear lands.
  // -------------------------------------------------------------------------
  always_comb begin : outputs
    grt_IU_IB      = grt;
    exit_grt_IU_IB = exit_grt;
    issue_count_IU = rst ? 32'd0 : issue_count;
  end

  // Grant invariants
  always_ff @(posedge clk) begin : invariants
    if (!rst) begin
      assert ($onehot0(grt_IU_IB))
        else $error("issue grant not one-hot: %b", grt_IU_IB);
      assert ($onehot0(exit_grt_IU_IB))
        else $error("exit grant not one-hot: %b", exit_grt_IU_IB);
      assert ((grt_IU_IB & exit_grt_IU_IB) == '0)
        else $error("issue and exit grant overlap: %b %b", grt_IU_IB, exit_grt_IU_IB);
      assert ((grt_IU_IB & ~req_IB_IU) == '0)
        else $error("issue grant without request: %b %b", grt_IU_IB, req_IB_IU);
    end
  end

endmodule
